// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_display_ctrl
// Description : Multi-digit BCD to 7-segment controller with leading-zero
//               suppression, per-digit blink and time-multiplexed scan output.
// Revision    : 1.0 - initial release
// ============================================================================

module seg7_display_ctrl #(
    parameter int NUM_DIGITS = 7,
    parameter int ACTIVE_LOW = 1,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [4*NUM_DIGITS-1:0] code,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    scan_mode,
    output logic [7*NUM_DIGITS-1:0] seg_static,
    output logic [6:0]              seg_scan,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int c_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int c_SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_BW-1:0]       c_BLINK_MAX = c_BW'(BLINK_DIV - 1);
    localparam logic [c_SW-1:0]       c_SCAN_MAX  = c_SW'(SCAN_DIV - 1);
    localparam logic [c_IW-1:0]       c_IDX_MAX   = c_IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            c_SEG_OFF   = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    // Patterns are kept in active-low form and inverted at the output stage.
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    f_decode = 7'b1000000;
            4'h1:    f_decode = 7'b1111001;
            4'h2:    f_decode = 7'b0100100;
            4'h3:    f_decode = 7'b0110000;
            4'h4:    f_decode = 7'b0011001;
            4'h5:    f_decode = 7'b0010010;
            4'h6:    f_decode = 7'b0000010;
            4'h7:    f_decode = 7'b1111000;
            4'h8:    f_decode = 7'b0000000;
            4'h9:    f_decode = 7'b0010000;
            4'hA:    f_decode = 7'b0111111;
            default: f_decode = 7'b1111111;
        endcase
    endfunction

    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [c_BW-1:0]         r_blink_cnt;
    logic                    r_blink_phase;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_SW-1:0]         r_scan_cnt;
    logic [c_SW-1:0]         w_scan_cnt_nxt;
    logic [c_IW-1:0]         r_idx;
    logic [c_IW-1:0]         w_idx_nxt;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [6:0]              w_seg_scan_nxt;
    logic [7*NUM_DIGITS-1:0] w_seg;
    logic [6:0]              w_dig [NUM_DIGITS];
    logic                    w_lead;
    logic                    w_blank;
    logic [3:0]              w_nib;
    logic [6:0]              w_pat;

    // Walk from the most significant digit; w_lead stays set while only zeros seen.
    always_comb begin
        w_lead  = 1'b1;
        w_blank = 1'b0;
        w_nib   = 4'h0;
        w_pat   = 7'h7F;
        w_seg   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_nib   = r_shadow[4*i +: 4];
            w_blank = (r_blink_phase && blink_mask[i]) ||
                      (lz_en && w_lead && (w_nib == 4'h0) && (i != 0));
            if (w_nib != 4'h0) begin
                w_lead = 1'b0;
            end
            w_pat          = w_blank ? 7'h7F : f_decode(w_nib);
            w_dig[i]       = (ACTIVE_LOW != 0) ? w_pat : ~w_pat;
            w_seg[7*i +: 7] = w_dig[i];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_scan_cnt_nxt = '0;
        w_idx_nxt      = '0;
        case (r_state)
            S_IDLE: begin
                if (scan_mode) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!scan_mode) begin
                    w_state_nxt = S_IDLE;
                end else if (r_scan_cnt == c_SCAN_MAX) begin
                    w_idx_nxt = (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
                end else begin
                    w_scan_cnt_nxt = r_scan_cnt + 1'b1;
                    w_idx_nxt      = r_idx;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Anode and segments come from the same next-index so they switch together.
        w_an_nxt       = c_AN_OFF;
        w_seg_scan_nxt = c_SEG_OFF;
        if (w_state_nxt == S_SCAN) begin
            w_an_nxt       = c_AN_OFF ^ (NUM_DIGITS'(1) << w_idx_nxt);
            w_seg_scan_nxt = w_dig[w_idx_nxt];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shadow      <= '1;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_state       <= S_IDLE;
            r_scan_cnt    <= '0;
            r_idx         <= '0;
            seg_static    <= {NUM_DIGITS{c_SEG_OFF}};
            seg_scan      <= c_SEG_OFF;
            an            <= c_AN_OFF;
        end else begin
            if (load) begin
                r_shadow <= code;
            end
            if (r_blink_cnt == c_BLINK_MAX) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
            r_state    <= w_state_nxt;
            r_scan_cnt <= w_scan_cnt_nxt;
            r_idx      <= w_idx_nxt;
            seg_static <= w_seg;
            seg_scan   <= w_seg_scan_nxt;
            an         <= w_an_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_display_ctrl
// Description : Randomised and directed bench for seg7_display_ctrl with a
//               behavioural display model (7-digit active-low, 4-digit active-high).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_seg7_display_ctrl;

    localparam int BD = 4;
    localparam int SD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [27:0] code = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [6:0]  blink_mask = '0;
    logic        scan_mode = 1'b0;

    logic [48:0] st7;
    logic [6:0]  ss7;
    logic [6:0]  an7;
    logic [27:0] st4;
    logic [6:0]  ss4;
    logic [3:0]  an4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_display_ctrl #(.NUM_DIGITS(7), .ACTIVE_LOW(1), .BLINK_DIV(BD), .SCAN_DIV(SD)) dut7 (
        .CLK(clk), .RST_N(rst_n), .code(code), .load(load), .lz_en(lz_en),
        .blink_mask(blink_mask), .scan_mode(scan_mode),
        .seg_static(st7), .seg_scan(ss7), .an(an7)
    );

    seg7_display_ctrl #(.NUM_DIGITS(4), .ACTIVE_LOW(0), .BLINK_DIV(BD), .SCAN_DIV(SD)) dut4 (
        .CLK(clk), .RST_N(rst_n), .code(code[15:0]), .load(load), .lz_en(lz_en),
        .blink_mask(blink_mask[3:0]), .scan_mode(scan_mode),
        .seg_static(st4), .seg_scan(ss4), .an(an4)
    );

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111,
              7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
        return t[n];
    endfunction

    // Digits above the most significant nonzero nibble are the suppressible ones.
    function automatic logic [48:0] model_static(input logic [27:0] sh, input logic lz,
                                                 input logic [6:0] mask, input logic ph,
                                                 input int nd, input bit al);
        logic [48:0] r;
        logic [6:0]  p;
        int          top;
        r   = '0;
        top = 0;
        for (int i = 0; i < nd; i++)
            if (sh[4*i +: 4] != 4'h0) top = i;
        for (int i = 0; i < nd; i++) begin
            if ((ph && mask[i]) || (lz && i > top)) p = 7'h7F;
            else p = dec(sh[4*i +: 4]);
            r[7*i +: 7] = al ? p : ~p;
        end
        return r;
    endfunction

    logic [27:0] m_sh;
    int          m_k;
    bit          m_scan;
    int          m_sk;
    logic [48:0] e_st7, e_st4;
    logic [6:0]  e_an7, e_ss7, e_ss4;
    logic [3:0]  e_an4;
    logic        ph;
    logic [48:0] s7, s4;
    int          k, i7, i4;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sh   <= '1;
            m_k    <= 0;
            m_scan <= 0;
            m_sk   <= 0;
            e_st7  <= {7{7'h7F}};
            e_st4  <= '0;
            e_an7  <= 7'h7F;
            e_an4  <= 4'h0;
            e_ss7  <= 7'h7F;
            e_ss4  <= 7'h00;
        end else begin
            ph = ((m_k / BD) % 2) == 1;
            s7 = model_static(m_sh, lz_en, blink_mask, ph, 7, 1);
            s4 = model_static(m_sh, lz_en, blink_mask, ph, 4, 0);
            e_st7 <= s7;
            e_st4 <= s4;
            if (load) m_sh <= code;
            m_k <= m_k + 1;
            if (scan_mode) begin
                k  = m_scan ? m_sk + 1 : 0;
                i7 = (k / SD) % 7;
                i4 = (k / SD) % 4;
                m_scan <= 1;
                m_sk   <= k;
                e_an7  <= ~(7'd1 << i7);
                e_an4  <= 4'd1 << i4;
                e_ss7  <= s7[7*i7 +: 7];
                e_ss4  <= s4[7*i4 +: 7];
            end else begin
                m_scan <= 0;
                m_sk   <= 0;
                e_an7  <= 7'h7F;
                e_an4  <= 4'h0;
                e_ss7  <= 7'h7F;
                e_ss4  <= 7'h00;
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (st7 !== {7{7'h7F}}) begin errors++; $display("FAIL rst_st7 got %h want all-blank", st7); end
        checks++; if (an7 !== 7'h7F) begin errors++; $display("FAIL rst_an7 got %b want 1111111", an7); end
        checks++; if (ss7 !== 7'h7F) begin errors++; $display("FAIL rst_ss7 got %b want 1111111", ss7); end
        checks++; if (st4 !== 28'h0) begin errors++; $display("FAIL rst_st4 got %h want 0", st4); end
        checks++; if (an4 !== 4'h0) begin errors++; $display("FAIL rst_an4 got %b want 0000", an4); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (st7 !== {7{7'h7F}}) begin errors++; $display("FAIL idle_st7 got %h want all-blank", st7); end
        checks++; if (an7 !== 7'h7F) begin errors++; $display("FAIL idle_an7 got %b want 1111111", an7); end
        checks++; if (st4 !== e_st4) begin errors++; $display("FAIL idle_st4 got %h want %h", st4, e_st4); end
    endtask

    task automatic test_lz;
        logic [48:0] full, supp;
        full = {7'b1000000, 7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010};
        supp = {7'h7F, 7'h7F, full[34:0]};
        lz_en = 1'b0; code = 28'h0012345; load = 1'b1;
        @(negedge clk); load = 1'b0;
        checks++; if (st7 !== {7{7'h7F}}) begin errors++; $display("FAIL lat_early got %h want blank", st7); end
        @(negedge clk);
        checks++; if (st7 !== full) begin errors++; $display("FAIL lz_off got %h want %h", st7, full); end
        checks++; if (st4 !== e_st4) begin errors++; $display("FAIL lz_off4 got %h want %h", st4, e_st4); end
        lz_en = 1'b1;
        @(negedge clk);
        checks++; if (st7 !== supp) begin errors++; $display("FAIL lz_on got %h want %h", st7, supp); end
        code = 28'h7654321;
        repeat (3) @(negedge clk);
        checks++; if (st7 !== supp) begin errors++; $display("FAIL noload got %h want %h", st7, supp); end
        code = 28'h0000000; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        checks++; if (st7 !== {{6{7'h7F}}, 7'b1000000}) begin errors++; $display("FAIL lz_zero got %h want %h", st7, {{6{7'h7F}}, 7'b1000000}); end
        checks++; if (st4 !== e_st4) begin errors++; $display("FAIL lz_zero4 got %h want %h", st4, e_st4); end
        code = 28'h00A0000; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        checks++; if (st7 !== {7'h7F, 7'h7F, 7'b0111111, {4{7'b1000000}}}) begin errors++; $display("FAIL lz_dash got %h want %h", st7, {7'h7F, 7'h7F, 7'b0111111, {4{7'b1000000}}}); end
        lz_en = 1'b0;
    endtask

    task automatic test_blink;
        int nblank;
        nblank = 0;
        code = 28'h0000008; load = 1'b1;
        @(negedge clk); load = 1'b0; blink_mask = 7'b0000001;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++; if (st7 !== e_st7) begin errors++; $display("FAIL blink_st7 c=%0d got %h want %h", c, st7, e_st7); end
            checks++; if (st4 !== e_st4) begin errors++; $display("FAIL blink_st4 c=%0d got %h want %h", c, st4, e_st4); end
            checks++; if (st7[48:7] !== {6{7'b1000000}}) begin errors++; $display("FAIL blink_steady c=%0d got %h", c, st7[48:7]); end
            if (st7[6:0] === 7'h7F) nblank++;
        end
        checks++; if (nblank !== 8) begin errors++; $display("FAIL blink_duty got %0d want 8", nblank); end
        blink_mask = '0;
    endtask

    task automatic test_scan;
        logic [6:0] ea;
        code = 28'h0123456; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk); scan_mode = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            ea = 7'h7F ^ (7'd1 << ((c / SD) % 7));
            checks++; if (an7 !== ea) begin errors++; $display("FAIL scan_an7 c=%0d got %b want %b", c, an7, ea); end
            checks++; if (ss7 !== dec(4'(6 - (c / SD) % 7))) begin errors++; $display("FAIL scan_ss7 c=%0d got %b want %b", c, ss7, dec(4'(6 - (c / SD) % 7))); end
            checks++; if (an4 !== 4'(1 << ((c / SD) % 4))) begin errors++; $display("FAIL scan_an4 c=%0d got %b", c, an4); end
            checks++; if (ss4 !== e_ss4) begin errors++; $display("FAIL scan_ss4 c=%0d got %b want %b", c, ss4, e_ss4); end
        end
        scan_mode = 1'b0;
        @(negedge clk);
        checks++; if (an7 !== 7'h7F) begin errors++; $display("FAIL scan_stop_an got %b want 1111111", an7); end
        checks++; if (ss7 !== 7'h7F) begin errors++; $display("FAIL scan_stop_ss got %b want 1111111", ss7); end
        checks++; if (an4 !== 4'h0) begin errors++; $display("FAIL scan_stop_an4 got %b want 0000", an4); end
    endtask

    task automatic test_reset_midscan;
        scan_mode = 1'b1;
        repeat (7) @(negedge clk);
        checks++; if (an7 !== 7'b1111011) begin errors++; $display("FAIL mid_idx2 got %b want 1111011", an7); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an7 !== 7'h7F) begin errors++; $display("FAIL async_an7 got %b want 1111111", an7); end
        checks++; if (an4 !== 4'h0) begin errors++; $display("FAIL async_an4 got %b want 0000", an4); end
        checks++; if (st7 !== {7{7'h7F}}) begin errors++; $display("FAIL async_st7 got %h want blank", st7); end
        @(negedge clk);
        checks++; if (ss7 !== 7'h7F) begin errors++; $display("FAIL held_ss7 got %b want 1111111", ss7); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (an7 !== 7'b1111110) begin errors++; $display("FAIL restart_an7 got %b want 1111110", an7); end
        checks++; if (an4 !== 4'b0001) begin errors++; $display("FAIL restart_an4 got %b want 0001", an4); end
        scan_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++; if (st7 !== e_st7) begin errors++; $display("FAIL rnd_st7 c=%0d got %h want %h", c, st7, e_st7); end
            checks++; if (st4 !== e_st4) begin errors++; $display("FAIL rnd_st4 c=%0d got %h want %h", c, st4, e_st4); end
            checks++; if (an7 !== e_an7) begin errors++; $display("FAIL rnd_an7 c=%0d got %b want %b", c, an7, e_an7); end
            checks++; if (an4 !== e_an4) begin errors++; $display("FAIL rnd_an4 c=%0d got %b want %b", c, an4, e_an4); end
            checks++; if (ss7 !== e_ss7) begin errors++; $display("FAIL rnd_ss7 c=%0d got %b want %b", c, ss7, e_ss7); end
            checks++; if (ss4 !== e_ss4) begin errors++; $display("FAIL rnd_ss4 c=%0d got %b want %b", c, ss4, e_ss4); end
            load       = ($urandom % 4) == 0;
            code       = 28'($urandom) & (($urandom % 2) ? 28'h00FFFFF : 28'hFFFFFFF);
            lz_en      = 1'($urandom);
            blink_mask = 7'($urandom);
            if (($urandom % 12) == 0) scan_mode = ~scan_mode;
        end
        load = 1'b0;
        scan_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lz();
        test_blink();
        test_scan();
        test_reset_midscan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
